pid_pwm_out: RTL and testbench

Output stage for the PID motor loop: samples the signed motor-power word that the PID controller publishes on its `ce` strobe and converts it into a glitch-free PWM signal with a direction bit for an H-bridge. Duty updates are double-buffered and applied only at PWM period boundaries. A direction reversal inserts a dead-time with PWM forced low. The block sits between the PID controller's `m_k_out` and the motor-driver pins, in the same `clk_pid` domain.

---
 rtl/pid_pwm_out.sv | 234 +++++++++++++++++++++++
 tb/tb_pid_pwm_out.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pid_pwm_out.sv
// pid_pwm_out - PWM output stage for the PID motor loop.
//
// Samples the signed motor-power word published by the PID controller on its
// ce strobe and turns it into a glitch-free PWM signal plus a direction bit
// for an H-bridge.
//
// The block has three states:
//   - IDLE: the period counter runs and pwm is held low until the first
//     command is applied.
//   - RUN:  new commands are double-buffered and take effect only at a
//     period boundary.
//   - DEAD: entered on a direction reversal. pwm is forced low for
//     `deadtime` clocks before the new direction and duty take effect.
//
// Parameters:
//   ow        width of signed m_k; magnitude, duty and counter are ow-1 bits
//   deadtime  forced-low clocks on a direction reversal (1..255)
//
// Ports:
//   clk_pid  in   block clock, shared with the PID controller
//   reset    in   asynchronous active-low reset
//   ce       in   one-cycle strobe, m_k valid in that cycle
//   m_k      in   signed motor power (two's complement)
//   pwm      out  registered PWM to the bridge enable
//   dir      out  registered direction, 0 = positive, 1 = negative
//   ack      out  one-cycle pulse in the first cycle a new duty drives pwm
//   ovr      out  one-cycle pulse when ce overwrites a still-pending value
module pid_pwm_out #(
  parameter int ow       = 12,
  parameter int deadtime = 16
) (
  input  logic                 clk_pid,
  input  logic                 reset,
  input  logic                 ce,
  input  logic signed [ow-1:0] m_k,
  output logic                 pwm,
  output logic                 dir,
  output logic                 ack,
  output logic                 ovr
);

  localparam int            MW        = ow - 1;
  localparam logic [MW-1:0] CNT_MAX   = {MW{1'b1}};
  localparam logic [MW-1:0] CNT_ZERO  = {MW{1'b0}};
  localparam logic [MW-1:0] CNT_ONE   = {{(MW-1){1'b0}}, 1'b1};
  localparam logic [7:0]    DEAD_LAST = 8'(deadtime - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } state_t;

  // Magnitude of a two's-complement word; the most negative value has no
  // positive counterpart and saturates to the largest magnitude.
  function automatic logic [MW-1:0] abs_sat(input logic [ow-1:0] v);
    logic [ow-1:0] neg;
    neg = ~v + {{(ow-1){1'b0}}, 1'b1};
    if (!v[ow-1])
      abs_sat = v[MW-1:0];
    else if (neg[ow-1])
      abs_sat = CNT_MAX;
    else
      abs_sat = neg[MW-1:0];
  endfunction

  state_t        state_r, state_nxt_s;
  logic [MW-1:0] cnt_r, cnt_nxt_s;
  logic [MW-1:0] duty_r, duty_nxt_s;
  logic          dir_r, dir_nxt_s;
  logic          pwm_r, pwm_nxt_s;
  logic          ack_r, ack_nxt_s;
  logic          ovr_r, ovr_nxt_s;
  logic [MW-1:0] pend_mag_r, pend_mag_nxt_s;
  logic          pend_sign_r, pend_sign_nxt_s;
  logic          pend_valid_r, pend_valid_nxt_s;
  logic [MW-1:0] tgt_mag_r, tgt_mag_nxt_s;
  logic          tgt_sign_r, tgt_sign_nxt_s;
  logic [7:0]    dead_cnt_r, dead_cnt_nxt_s;

  logic [MW-1:0] mag_s;
  logic          eff_valid_s, eff_sign_s;
  logic [MW-1:0] eff_mag_s;
  logic          boundary_s, dir_ref_s, rev_s, dead_done_s;
  logic          apply_run_s, enter_dead_s, consume_s;

  // Decode of the command seen at this edge: a ce coinciding with a boundary
  // bypasses the pending register so the fresh value is applied directly.
  always_comb begin
    mag_s = abs_sat(m_k);
    if (ce) begin
      eff_valid_s = 1'b1;
      eff_mag_s   = mag_s;
      eff_sign_s  = m_k[ow-1];
    end else begin
      eff_valid_s = pend_valid_r;
      eff_mag_s   = pend_mag_r;
      eff_sign_s  = pend_sign_r;
    end
    boundary_s = (state_r != ST_DEAD) && (cnt_r == CNT_MAX);
    // Nothing has been driven yet in IDLE, so the reference direction is positive.
    if (state_r == ST_IDLE)
      dir_ref_s = 1'b0;
    else
      dir_ref_s = dir_r;
    // A zero command never reverses the bridge.
    rev_s       = (eff_mag_s != CNT_ZERO) && (eff_sign_s != dir_ref_s);
    dead_done_s = (state_r == ST_DEAD) && (dead_cnt_r == DEAD_LAST);
  end

  // State register.
  always_ff @(posedge clk_pid or negedge reset) begin
    if (!reset)
      state_r <= ST_IDLE;
    else
      state_r <= state_nxt_s;
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_RUN: begin
        if (boundary_s && eff_valid_s)
          state_nxt_s = rev_s ? ST_DEAD : ST_RUN;
        else
          state_nxt_s = state_r;
      end
      ST_DEAD: begin
        if (dead_done_s)
          state_nxt_s = ST_RUN;
        else
          state_nxt_s = ST_DEAD;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output and datapath next values; pwm is computed from next-cycle values
  // so that the registered pwm, duty and ack line up in the same cycle.
  always_comb begin
    consume_s    = boundary_s && eff_valid_s;
    apply_run_s  = consume_s && !rev_s;
    enter_dead_s = consume_s && rev_s;

    if (state_r == ST_RUN || state_r == ST_IDLE)
      cnt_nxt_s = cnt_r + CNT_ONE;
    else
      cnt_nxt_s = CNT_ZERO;

    if (apply_run_s)
      duty_nxt_s = eff_mag_s;
    else if (enter_dead_s)
      duty_nxt_s = CNT_ZERO;
    else if (dead_done_s)
      duty_nxt_s = tgt_mag_r;
    else
      duty_nxt_s = duty_r;

    if (dead_done_s)
      dir_nxt_s = tgt_sign_r;
    else
      dir_nxt_s = dir_r;

    ack_nxt_s = apply_run_s || dead_done_s;
    ovr_nxt_s = ce && pend_valid_r;

    if (consume_s) begin
      pend_valid_nxt_s = 1'b0;
      pend_mag_nxt_s   = pend_mag_r;
      pend_sign_nxt_s  = pend_sign_r;
    end else if (ce) begin
      pend_valid_nxt_s = 1'b1;
      pend_mag_nxt_s   = mag_s;
      pend_sign_nxt_s  = m_k[ow-1];
    end else begin
      pend_valid_nxt_s = pend_valid_r;
      pend_mag_nxt_s   = pend_mag_r;
      pend_sign_nxt_s  = pend_sign_r;
    end

    if (enter_dead_s) begin
      tgt_mag_nxt_s  = eff_mag_s;
      tgt_sign_nxt_s = eff_sign_s;
    end else begin
      tgt_mag_nxt_s  = tgt_mag_r;
      tgt_sign_nxt_s = tgt_sign_r;
    end

    if (state_r == ST_DEAD)
      dead_cnt_nxt_s = dead_cnt_r + 8'd1;
    else
      dead_cnt_nxt_s = 8'd0;

    pwm_nxt_s = (state_nxt_s == ST_RUN) && (cnt_nxt_s < duty_nxt_s);
  end

  // Datapath and output registers.
  always_ff @(posedge clk_pid or negedge reset) begin
    if (!reset) begin
      cnt_r        <= CNT_ZERO;
      duty_r       <= CNT_ZERO;
      dir_r        <= 1'b0;
      pwm_r        <= 1'b0;
      ack_r        <= 1'b0;
      ovr_r        <= 1'b0;
      pend_mag_r   <= CNT_ZERO;
      pend_sign_r  <= 1'b0;
      pend_valid_r <= 1'b0;
      tgt_mag_r    <= CNT_ZERO;
      tgt_sign_r   <= 1'b0;
      dead_cnt_r   <= 8'd0;
    end else begin
      cnt_r        <= cnt_nxt_s;
      duty_r       <= duty_nxt_s;
      dir_r        <= dir_nxt_s;
      pwm_r        <= pwm_nxt_s;
      ack_r        <= ack_nxt_s;
      ovr_r        <= ovr_nxt_s;
      pend_mag_r   <= pend_mag_nxt_s;
      pend_sign_r  <= pend_sign_nxt_s;
      pend_valid_r <= pend_valid_nxt_s;
      tgt_mag_r    <= tgt_mag_nxt_s;
      tgt_sign_r   <= tgt_sign_nxt_s;
      dead_cnt_r   <= dead_cnt_nxt_s;
    end
  end

  assign pwm = pwm_r;
  assign dir = dir_r;
  assign ack = ack_r;
  assign ovr = ovr_r;

endmodule

// File: tb/tb_pid_pwm_out.sv
// tb_pid_pwm_out - directed self-checking bench for pid_pwm_out (ow=12,
// deadtime=16, period 2048 clocks). Inputs are driven and outputs sampled
// 1 time unit after each rising clock edge.
module tb_pid_pwm_out;

  logic                  clk_pid = 1'b0;
  logic                  reset   = 1'b0;
  logic                  ce      = 1'b0;
  logic signed [11:0]    m_k     = 12'sd0;
  logic                  pwm, dir, ack, ovr;

  int checks = 0;
  int errors = 0;
  int n, h, a, d, ok;

  pid_pwm_out #(.ow(12), .deadtime(16)) dut (
    .clk_pid (clk_pid),
    .reset   (reset),
    .ce      (ce),
    .m_k     (m_k),
    .pwm     (pwm),
    .dir     (dir),
    .ack     (ack),
    .ovr     (ovr)
  );

  // Free-running block clock.
  always #5 clk_pid = ~clk_pid;

  task automatic tick();
    @(posedge clk_pid);
    #1;
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  // One-cycle ce with the given power; returns one cycle later.
  task automatic strobe(input int v);
    ce  = 1'b1;
    m_k = 12'(v);
    tick();
    ce  = 1'b0;
  endtask

  // Ticks until ack (bounded). n = ticks taken, hi = pwm-high samples before
  // ack, db = dir changes that followed a pwm-high sample.
  task automatic wait_ack(output int cnt, output int hi, output int db);
    logic pd, pp;
    cnt = 0; hi = 0; db = 0; pd = dir; pp = pwm;
    while (cnt < 5000) begin
      tick();
      cnt++;
      if (dir !== pd && pp === 1'b1) db++;
      pd = dir; pp = pwm;
      if (ack === 1'b1) break;
      if (pwm === 1'b1) hi++;
    end
  endtask

  // Observes one full 2048-clock period starting at the current sample.
  task automatic measure(output int hi, output int acks, output int db);
    logic pd, pp;
    hi = 0; acks = 0; db = 0; pd = dir; pp = pwm;
    for (int i = 0; i < 2048; i++) begin
      if (i > 0) begin
        if (dir !== pd && pp === 1'b1) db++;
        if (ack === 1'b1) acks++;
      end
      if (pwm === 1'b1) hi++;
      pd = dir; pp = pwm;
      tick();
    end
  endtask

  task automatic test_reset();
    ticks(3);
    checks++; if (pwm !== 1'b0) begin errors++; $display("FAIL rst_pwm got %b exp 0", pwm); end
    checks++; if (dir !== 1'b0) begin errors++; $display("FAIL rst_dir got %b exp 0", dir); end
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b exp 0", ack); end
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL rst_ovr got %b exp 0", ovr); end
    reset = 1'b1;
  endtask

  task automatic test_first_positive();
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (pwm === 1'b0 && ack === 1'b0) ok++;
    end
    checks++; if (ok !== 10) begin errors++; $display("FAIL t1_idle_low got %0d exp 10", ok); end
    strobe(512);
    wait_ack(n, h, d);
    checks++; if (n !== 2037) begin errors++; $display("FAIL t1_latency got %0d exp 2037", n); end
    checks++; if (h !== 0) begin errors++; $display("FAIL t1_idle_highs got %0d exp 0", h); end
    checks++; if (dir !== 1'b0 || pwm !== 1'b1) begin errors++; $display("FAIL t1_ack_state got dir=%b pwm=%b exp dir=0 pwm=1", dir, pwm); end
    for (int p = 0; p < 2; p++) begin
      measure(h, a, d);
      checks++; if (h !== 512) begin errors++; $display("FAIL t1_period%0d_highs got %0d exp 512", p, h); end
      checks++; if (a !== 0) begin errors++; $display("FAIL t1_period%0d_acks got %0d exp 0", p, a); end
    end
  endtask

  task automatic test_full_negative();
    strobe(-2048);
    wait_ack(n, h, d);
    checks++; if (n !== 2063) begin errors++; $display("FAIL t2_latency got %0d exp 2063", n); end
    checks++; if (h !== 510) begin errors++; $display("FAIL t2_highs_before got %0d exp 510", h); end
    checks++; if (d !== 0) begin errors++; $display("FAIL t2_dir_while_pwm got %0d exp 0", d); end
    checks++; if (dir !== 1'b1) begin errors++; $display("FAIL t2_dir got %b exp 1", dir); end
    measure(h, a, d);
    checks++; if (h !== 2047) begin errors++; $display("FAIL t2_period_highs got %0d exp 2047", h); end
  endtask

  task automatic test_zero_command();
    strobe(0);
    wait_ack(n, h, d);
    checks++; if (n !== 2047) begin errors++; $display("FAIL t5_latency got %0d exp 2047", n); end
    checks++; if (h !== 2045) begin errors++; $display("FAIL t5_highs_before got %0d exp 2045", h); end
    checks++; if (dir !== 1'b1 || pwm !== 1'b0) begin errors++; $display("FAIL t5_ack_state got dir=%b pwm=%b exp dir=1 pwm=0", dir, pwm); end
    measure(h, a, d);
    checks++; if (h !== 0) begin errors++; $display("FAIL t5_period_highs got %0d exp 0", h); end
    checks++; if (dir !== 1'b1) begin errors++; $display("FAIL t5_dir_kept got %b exp 1", dir); end
    // Back to positive: a reversal from dir=1 with duty 0.
    strobe(512);
    wait_ack(n, h, d);
    checks++; if (n !== 2063) begin errors++; $display("FAIL t5b_latency got %0d exp 2063", n); end
    checks++; if (dir !== 1'b0 || pwm !== 1'b1) begin errors++; $display("FAIL t5b_ack_state got dir=%b pwm=%b exp dir=0 pwm=1", dir, pwm); end
  endtask

  task automatic test_overwrite();
    strobe(100);
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL t4_first_ovr got %b exp 0", ovr); end
    ticks(50);
    strobe(300);
    checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL t4_second_ovr got %b exp 1", ovr); end
    tick();
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL t4_ovr_single got %b exp 0", ovr); end
    wait_ack(n, h, d);
    checks++; if (n !== 1995) begin errors++; $display("FAIL t4_latency got %0d exp 1995", n); end
    checks++; if (h !== 458) begin errors++; $display("FAIL t4_highs_before got %0d exp 458", h); end
    measure(h, a, d);
    checks++; if (h !== 300) begin errors++; $display("FAIL t4_period_highs got %0d exp 300", h); end
  endtask

  task automatic test_reversal_deadtime();
    strobe(512);
    wait_ack(n, h, d);
    checks++; if (n !== 2047) begin errors++; $display("FAIL t3_setup_latency got %0d exp 2047", n); end
    checks++; if (h !== 298) begin errors++; $display("FAIL t3_setup_highs got %0d exp 298", h); end
    strobe(-256);
    ticks(2046);
    checks++; if (pwm !== 1'b0 || ack !== 1'b0) begin errors++; $display("FAIL t3_pre_boundary got pwm=%b ack=%b exp 0 0", pwm, ack); end
    ok = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (pwm === 1'b0 && dir === 1'b0 && ack === 1'b0) ok++;
    end
    checks++; if (ok !== 16) begin errors++; $display("FAIL t3_dead_low got %0d exp 16", ok); end
    tick();
    checks++; if (ack !== 1'b1 || dir !== 1'b1 || pwm !== 1'b1) begin errors++; $display("FAIL t3_dead_exit got ack=%b dir=%b pwm=%b exp 1 1 1", ack, dir, pwm); end
    measure(h, a, d);
    checks++; if (h !== 256) begin errors++; $display("FAIL t3_period_highs got %0d exp 256", h); end
    checks++; if (a !== 0 || d !== 0) begin errors++; $display("FAIL t3_period_quiet got acks=%0d dirbad=%0d exp 0 0", a, d); end
  endtask

  task automatic test_reset_in_dead();
    strobe(200);
    ticks(2046);
    ticks(5);
    checks++; if (pwm !== 1'b0 || dir !== 1'b1) begin errors++; $display("FAIL t6_in_dead got pwm=%b dir=%b exp 0 1", pwm, dir); end
    reset = 1'b0;
    #1;
    checks++; if (pwm !== 1'b0 || dir !== 1'b0 || ack !== 1'b0 || ovr !== 1'b0) begin errors++; $display("FAIL t6_async_reset got pwm=%b dir=%b ack=%b ovr=%b exp 0 0 0 0", pwm, dir, ack, ovr); end
    ticks(3);
    reset = 1'b1;
    h = 0; a = 0;
    for (int i = 0; i < 2100; i++) begin
      tick();
      if (pwm === 1'b1) h++;
      if (ack === 1'b1) a++;
    end
    checks++; if (h !== 0 || a !== 0) begin errors++; $display("FAIL t6_idle_after got highs=%0d acks=%0d exp 0 0", h, a); end
    strobe(50);
    wait_ack(n, h, d);
    checks++; if (n !== 1995) begin errors++; $display("FAIL t6_latency got %0d exp 1995", n); end
    checks++; if (dir !== 1'b0 || pwm !== 1'b1) begin errors++; $display("FAIL t6_ack_state got dir=%b pwm=%b exp dir=0 pwm=1", dir, pwm); end
  endtask

  initial begin
    test_reset();
    test_first_positive();
    test_full_negative();
    test_zero_command();
    test_overwrite();
    test_reversal_deadtime();
    test_reset_in_dead();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
